// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the
// tagging scheme used to split 12-bit words across two serial bytes.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int UART_BYTE_W = 8;

    // Word-load byte layout: bit 7 tags the half, bit 6 is spare, bits 5:0 carry data.
    localparam int   TAG_BIT  = 7;
    localparam logic TAG_HIGH = 1'b1;
    localparam logic TAG_LOW  = 1'b0;
    localparam int   HALF_W   = 6;
    localparam int   WORD_W   = 2 * HALF_W;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM paced by ce,
// one-clk byte-valid pulse and sticky framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   rxd,
    output logic                   byte_vld,
    output logic [UART_BYTE_W-1:0] byte_data,
    output logic                   active,
    output logic                   frame_err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state;
    logic          rxd_s1;
    logic          rxd_s2;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            rxd_s1    <= 1'b1;
            rxd_s2    <= 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            active    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            byte_vld <= 1'b0;
            if (ce) begin
                case (state)
                    RX_IDLE: begin
                        if (!rxd_s2) begin
                            state    <= RX_START;
                            tick_cnt <= '0;
                            active   <= 1'b1;
                        end
                    end
                    // Re-check the line half a bit in; a short low pulse is a glitch.
                    RX_START: begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            if (!rxd_s2) begin
                                state <= RX_DATA;
                            end else begin
                                state  <= RX_IDLE;
                                active <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (tick_cnt == TICK_FULL) begin
                            tick_cnt  <= '0;
                            byte_data <= {rxd_s2, byte_data[UART_BYTE_W-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (tick_cnt == TICK_FULL) begin
                            tick_cnt <= '0;
                            active   <= 1'b0;
                            if (rxd_s2) begin
                                byte_vld <= 1'b1;
                                state    <= RX_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= RX_WAIT_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    RX_WAIT_IDLE: begin
                        if (rxd_s2) begin
                            state <= RX_IDLE;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Program-memory loader: pairs tagged high/low bytes from uart_rx into 12-bit
// words and writes them to consecutive addresses until WORD_COUNT words land.
module uart_loader
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int WORD_COUNT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              rxd,
    output logic              o_we,
    output logic [WORD_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_data,
    output logic              o_active,
    output logic              o_done,
    output logic              o_frame_err,
    output logic              o_seq_err
);

    localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(WORD_COUNT - 1);

    logic                   rx_vld;
    logic [UART_BYTE_W-1:0] rx_byte;
    logic                   pending;
    logic [HALF_W-1:0]      hi_half;
    logic                   unused_spare_bit;

    // Bit 6 of a load byte carries no information.
    assign unused_spare_bit = rx_byte[6];

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .rxd      (rxd),
        .byte_vld (rx_vld),
        .byte_data(rx_byte),
        .active   (o_active),
        .frame_err(o_frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            o_we      <= 1'b0;
            o_addr    <= '0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_seq_err <= 1'b0;
            pending   <= 1'b0;
            hi_half   <= '0;
        end else begin
            o_we <= 1'b0;
            if (o_we && (o_addr != LAST_ADDR)) begin
                o_addr <= o_addr + 1'b1;
            end
            if (rx_vld && !o_done) begin
                case (rx_byte[TAG_BIT])
                    TAG_HIGH: begin
                        pending <= 1'b1;
                        hi_half <= rx_byte[HALF_W-1:0];
                    end
                    TAG_LOW: begin
                        if (pending) begin
                            o_we    <= 1'b1;
                            o_data  <= {hi_half, rx_byte[HALF_W-1:0]};
                            pending <= 1'b0;
                            if (o_addr == LAST_ADDR) begin
                                o_done <= 1'b1;
                            end
                        end else begin
                            o_seq_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
